// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and its tick generator.
package uart_pkg;

    localparam int MIN_DATA_BITS  = 5;
    localparam int MAX_DATA_BITS  = 9;
    localparam int MIN_BREAK_BITS = 2;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_e;

    typedef enum logic [1:0] {
        STOP_1     = 2'd0,
        STOP_1P5   = 2'd1,
        STOP_2     = 2'd2,
        STOP_2_ALT = 2'd3
    } stop_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5,
        ST_GUARD  = 3'd6
    } uart_state_e;

    // Character length actually used for a requested length.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        if (req < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end else if (req > max_bits) begin
            return max_bits;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Host-side port bundle of the UART transmitter.
//
// Handshake: a character moves on a rising CLK edge where iVALID and oREADY
// are both high. oREADY is a function of transmitter state and iBREAK only,
// never of iVALID, so a source may wait for oREADY before raising iVALID or
// hold iVALID high and let the transmitter take the character when it can.
// Configuration inputs are sampled together with iDATA at that edge.
interface uart_tx_gen_if #(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int DIV_WIDTH      = 16
) ();
    import uart_pkg::*;

    logic [DIV_WIDTH-1:0]      iBAUD_DIV;
    logic [3:0]                iDATA_BITS;
    logic [2:0]                iPARITY_MODE;
    logic [1:0]                iSTOP_BITS;
    logic                      iBREAK;
    logic                      iVALID;
    logic [MAX_DATA_WIDTH-1:0] iDATA;
    logic                      oREADY;
    logic                      oUART_TX;
    logic                      oBUSY;
    logic                      oDONE;
    uart_state_e               oSTATE;

    modport master (
        output iBAUD_DIV, iDATA_BITS, iPARITY_MODE, iSTOP_BITS, iBREAK, iVALID, iDATA,
        input  oREADY, oUART_TX, oBUSY, oDONE, oSTATE
    );

    modport slave (
        input  iBAUD_DIV, iDATA_BITS, iPARITY_MODE, iSTOP_BITS, iBREAK, iVALID, iDATA,
        output oREADY, oUART_TX, oBUSY, oDONE, oSTATE
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every iDIV+1 clocks.
// Held at phase zero while iCLEAR is high so the first tick after release
// arrives exactly iDIV+1 clocks later.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iCLEAR,
    input  logic [DIV_WIDTH-1:0] iDIV,
    output logic                 oTICK
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 wrap;

    assign wrap  = (cnt_q == iDIV);
    assign oTICK = wrap && !iCLEAR;

    // Next divider phase: wrap at iDIV, restart on clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (iCLEAR || wrap) begin
            cnt_d = '0;
        end
    end

    // Divider phase register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: configurable character length, parity, stop length and
// baud divider, with break generation. All line-side outputs are registered.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int OVER_SAMPLING  = 16,
    parameter int DIV_WIDTH      = 16
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_gen_if.slave bus
);

    // Tick counter spans up to two bit times (2 stop bits, minimum break).
    localparam int TW = $clog2(OVER_SAMPLING * 2);
    localparam logic [TW-1:0] T_BIT = TW'(OVER_SAMPLING - 1);
    localparam logic [TW-1:0] T_1P5 = TW'((OVER_SAMPLING * 3) / 2 - 1);
    localparam logic [TW-1:0] T_2   = TW'(OVER_SAMPLING * 2 - 1);
    localparam logic [TW-1:0] T_BRK = TW'(OVER_SAMPLING * MIN_BREAK_BITS - 1);
    localparam logic [3:0] NB_MAX = (MAX_DATA_WIDTH > MAX_DATA_BITS) ?
                                    4'(MAX_DATA_BITS) : 4'(MAX_DATA_WIDTH);

    uart_state_e               state_q;
    logic                      tx_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic [MAX_DATA_WIDTH-1:0] sh_q;
    logic                      par_q;
    logic [3:0]                nbits_q;
    parity_e                   pmode_q;
    stop_e                     stop_q;
    logic [DIV_WIDTH-1:0]      div_q;
    logic [TW-1:0]             tick_cnt_q;
    logic [3:0]                bit_cnt_q;

    logic          tick;
    logic [TW-1:0] bit_tgt;
    logic          bit_end;
    logic          par_bit;

    // Divider runs only while a frame or break is active, so each one starts
    // on a fresh tick phase.
    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .CLK   (CLK),
        .RST   (RST),
        .iCLEAR(state_q == ST_IDLE),
        .iDIV  (div_q),
        .oTICK (tick)
    );

    // Last tick index of the current line element.
    always_comb begin
        bit_tgt = T_BIT;
        if (state_q == ST_STOP) begin
            case (stop_q)
                STOP_1:   bit_tgt = T_BIT;
                STOP_1P5: bit_tgt = T_1P5;
                default:  bit_tgt = T_2;
            endcase
        end else if (state_q == ST_BREAK) begin
            bit_tgt = T_BRK;
        end
    end

    assign bit_end = tick && (tick_cnt_q == bit_tgt);

    // Parity bit from the running XOR of the transmitted data bits.
    always_comb begin
        case (pmode_q)
            PAR_EVEN: par_bit = par_q;
            PAR_ODD:  par_bit = ~par_q;
            PAR_MARK: par_bit = 1'b1;
            default:  par_bit = 1'b0;
        endcase
    end

    // Frame/break sequencer with registered line and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            nbits_q    <= 4'd8;
            pmode_q    <= PAR_NONE;
            stop_q     <= STOP_1;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (tick && state_q != ST_BREAK) begin
                tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (bus.iBREAK) begin
                        state_q <= ST_BREAK;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        div_q   <= bus.iBAUD_DIV;
                    end else if (bus.iVALID && ready_q) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        div_q   <= bus.iBAUD_DIV;
                        sh_q    <= bus.iDATA;
                        par_q   <= 1'b0;
                        nbits_q <= clamp_data_bits(bus.iDATA_BITS, NB_MAX);
                        pmode_q <= (bus.iPARITY_MODE > 3'd4) ? PAR_NONE
                                                             : parity_e'(bus.iPARITY_MODE);
                        stop_q  <= stop_e'(bus.iSTOP_BITS);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        tx_q      <= sh_q[0];
                        par_q     <= sh_q[0];
                        sh_q      <= sh_q >> 1;
                        bit_cnt_q <= 4'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == nbits_q) begin
                            if (pmode_q != PAR_NONE) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q      <= sh_q[0];
                            par_q     <= par_q ^ sh_q[0];
                            sh_q      <= sh_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Count to the minimum length, then hold there until released.
                    if (tick && tick_cnt_q != T_BRK) begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                    if (bit_end && !bus.iBREAK) begin
                        state_q    <= ST_GUARD;
                        tx_q       <= 1'b1;
                        tick_cnt_q <= '0;
                    end
                end
                ST_GUARD: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oREADY   = ready_q && (state_q == ST_IDLE) && !bus.iBREAK;
    assign bus.oUART_TX = tx_q;
    assign bus.oBUSY    = busy_q;
    assign bus.oDONE    = done_q;
    assign bus.oSTATE   = state_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: line waveform, status flags, break and reset.
module tb_uart_tx_gen;
    import uart_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_gen_if #(.MAX_DATA_WIDTH(9), .DIV_WIDTH(16)) bus ();

    uart_tx_gen #(
        .MAX_DATA_WIDTH(9),
        .OVER_SAMPLING (16),
        .DIV_WIDTH     (16)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {line, busy, ready, done}
    function automatic logic [31:0] status();
        return {28'd0, bus.oUART_TX, bus.oBUSY, bus.oREADY, bus.oDONE};
    endfunction

    task automatic send(input logic [8:0] data, input logic [3:0] nb, input logic [2:0] pm,
                        input logic [1:0] sb, input logic [15:0] div);
        bus.iDATA        = data;
        bus.iDATA_BITS   = nb;
        bus.iPARITY_MODE = pm;
        bus.iSTOP_BITS   = sb;
        bus.iBAUD_DIV    = div;
        bus.iVALID       = 1'b1;
        #1;
        chk("ready_before_send", bus.oREADY, 1);
        @(posedge clk);
        #1;
        bus.iVALID = 1'b0;
    endtask

    // Expected line element i lasts cpb clocks (last element: last clocks).
    task automatic check_line(input string tag, input logic [15:0] bits, input int nbits,
                              input int cpb, input int last);
        int dur;
        for (int i = 0; i < nbits; i++) begin
            dur = (i == nbits - 1) ? last : cpb;
            for (int c = 0; c < dur; c++) begin
                @(negedge clk);
                chk($sformatf("%s elem%0d clk%0d", tag, i, c), status(),
                    {28'd0, bits[i], 3'b100});
            end
        end
    endtask

    task automatic check_frame_end(input string tag);
        @(negedge clk);
        chk({tag, "_done_cycle"}, status(), 32'b1011);
        @(negedge clk);
        chk({tag, "_after_done"}, status(), 32'b1010);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.iBAUD_DIV    = 16'd0;
        bus.iDATA_BITS   = 4'd8;
        bus.iPARITY_MODE = 3'd0;
        bus.iSTOP_BITS   = 2'd0;
        bus.iBREAK       = 1'b0;
        bus.iVALID       = 1'b0;
        bus.iDATA        = 9'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_status", status(), 32'b1000);
        chk("reset_state", bus.oSTATE, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", status(), 32'b1010);

        // 1: 8N1, 0x55, 16 clocks per bit
        send(9'h055, 4'd8, 3'd0, 2'd0, 16'd0);
        check_line("t1", 16'b1010101010, 10, 16, 16);
        check_frame_end("t1");

        // 2: 7 bits, odd parity, 2 stop; bit 8 of iDATA must not appear
        send(9'h1A3, 4'd7, 3'd2, 2'd2, 16'd0);
        check_line("t2", 16'b1001000110, 10, 16, 32);
        check_frame_end("t2");

        // 3: 9 bits, mark parity, 1.5 stop, divider 2
        send(9'h100, 4'd9, 3'd3, 2'd1, 16'd2);
        check_line("t3", 16'b111000000000, 12, 48, 72);
        check_frame_end("t3");

        // 4: back-to-back with iVALID held, config change during frame 1
        bus.iDATA        = 9'h000;
        bus.iDATA_BITS   = 4'd8;
        bus.iPARITY_MODE = 3'd0;
        bus.iSTOP_BITS   = 2'd0;
        bus.iBAUD_DIV    = 16'd0;
        bus.iVALID       = 1'b1;
        @(posedge clk);
        #1;
        bus.iDATA        = 9'h0FF;
        bus.iPARITY_MODE = 3'd1;
        check_line("t4a", 16'b1000000000, 10, 16, 16);
        @(negedge clk);
        chk("t4_idle_gap", status(), 32'b1011);
        @(posedge clk);
        #1;
        bus.iVALID = 1'b0;
        check_line("t4b", 16'b10111111110, 11, 16, 16);
        check_frame_end("t4b");
        bus.iPARITY_MODE = 3'd0;

        // 5a: one-clock break pulse from idle
        bus.iBREAK = 1'b1;
        #1;
        chk("t5_ready_masked_by_break", bus.oREADY, 0);
        @(posedge clk);
        #1;
        bus.iBREAK = 1'b0;
        check_line("t5a_break", 16'b10, 2, 32, 16);
        @(negedge clk);
        chk("t5a_after_guard", status(), 32'b1010);

        // 5b: break requested mid-frame waits for the frame to finish
        send(9'h00F, 4'd8, 3'd0, 2'd0, 16'd0);
        bus.iBREAK = 1'b1;
        check_line("t5b_frame", 16'b1000011110, 10, 16, 16);
        @(negedge clk);
        chk("t5b_done_no_ready", status(), 32'b1001);
        @(posedge clk);
        #1;
        bus.iBREAK = 1'b0;
        check_line("t5b_break", 16'b10, 2, 32, 16);
        @(negedge clk);
        chk("t5b_after_guard", status(), 32'b1010);

        // 6a: reset during data bit 3
        send(9'h000, 4'd8, 3'd0, 2'd0, 16'd0);
        repeat (69) @(negedge clk);
        @(negedge clk);
        chk("t6_before_reset", status(), 32'b0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_in_reset", status(), 32'b1000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t6_quiet%0d", i), status(), 32'b1010);
        end

        // 6b: character length clamping
        send(9'h1F5, 4'd3, 3'd0, 2'd0, 16'd0);
        check_line("t6_len5", 16'b1101010, 7, 16, 16);
        check_frame_end("t6_len5");
        send(9'h055, 4'd12, 3'd0, 2'd0, 16'd0);
        check_line("t6_len9", 16'b10010101010, 11, 16, 16);
        check_frame_end("t6_len9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
